// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit byte-to-bit path.
package usb_tx_pkg;
   localparam int          BYTE_W          = 8;
   localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
   localparam logic [15:0] CRC16_INIT      = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_SHIFT,
      ST_CRC,
      ST_UNDERRUN
   } tx_state_t;
endpackage

// File: rtl/usb_crc16_serial.sv
// Bit-serial USB CRC16 (reflected 0xA001): one bit folded in per cycle with i_en high.
// Result visible the cycle after the update; i_init has priority over i_en; no backpressure.
module usb_crc16_serial
   import usb_tx_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_init,
   input  logic        i_en,
   input  logic        i_bit,
   output logic [15:0] o_crc
);
   logic [15:0] r_crc;
   logic        w_fb;

   assign w_fb = r_crc[0] ^ i_bit;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_init) begin
         r_crc <= CRC16_INIT;
      end else if (i_en) begin
         r_crc <= (r_crc >> 1) ^ (w_fb ? CRC16_POLY_REFL : 16'h0000);
      end
   end

   assign o_crc = r_crc;
endmodule

// File: rtl/usb_tx_serializer.sv
// Packet bytes in (valid/ready, one-byte skid) -> LSB-first bits out, advanced by i_bit_ack; first bit 1 cycle after first byte.
// Optional CRC16 trailer with USB_TX_CRC16_EN; byte_ready drops while the skid is full or after the last byte is taken.
module usb_tx_serializer
   import usb_tx_pkg::*;
#(
   parameter int BYTE_W = 8
) (
   input  logic              i_clk48,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [BYTE_W-1:0] i_byte_data,
   input  logic              i_byte_valid,
   input  logic              i_byte_last,
   output logic              o_byte_ready,
   output logic              o_bit_out,
   output logic              o_last_bit,
   input  logic              i_bit_ack,
   output logic              o_busy,
   output logic              o_underrun
);
   localparam int IDX_W = $clog2(BYTE_W);

   tx_state_t         r_state;
   logic [BYTE_W-1:0] r_sreg;
   logic [BYTE_W-1:0] r_skid;
   logic              r_cur_last;
   logic              r_skid_last;
   logic              r_skid_full;
   logic              r_last_acc;
   logic              r_underrun;
   logic [IDX_W-1:0]  r_bit_idx;
   logic              w_xfer;
   logic              w_idx_end;

`ifdef USB_TX_CRC16_EN
   logic              r_pid_byte;
   logic [3:0]        r_crc_idx;
   logic [15:0]       w_crc;

   // The PID is sent but never folded into the CRC.
   usb_crc16_serial u_crc (
      .i_clk   (i_clk48),
      .i_reset (i_reset),
      .i_init  ((r_state == ST_IDLE) && i_start),
      .i_en    ((r_state == ST_SHIFT) && i_bit_ack && !r_pid_byte),
      .i_bit   (r_sreg[0]),
      .o_crc   (w_crc)
   );
`endif

   assign o_byte_ready = ((r_state == ST_FILL) || (r_state == ST_SHIFT))
                         && !r_skid_full && !r_last_acc;
   assign w_xfer       = i_byte_valid && o_byte_ready;
   assign w_idx_end    = (r_bit_idx == IDX_W'(BYTE_W - 1));

   always_ff @(posedge i_clk48) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_sreg      <= '0;
         r_skid      <= '0;
         r_cur_last  <= 1'b0;
         r_skid_last <= 1'b0;
         r_skid_full <= 1'b0;
         r_last_acc  <= 1'b0;
         r_underrun  <= 1'b0;
         r_bit_idx   <= '0;
`ifdef USB_TX_CRC16_EN
         r_pid_byte  <= 1'b0;
         r_crc_idx   <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_state     <= ST_FILL;
                  r_underrun  <= 1'b0;
                  r_last_acc  <= 1'b0;
                  r_skid_full <= 1'b0;
               end
            end
            ST_FILL: begin
               if (w_xfer) begin
                  r_sreg     <= i_byte_data;
                  r_cur_last <= i_byte_last;
                  r_last_acc <= i_byte_last;
                  r_bit_idx  <= '0;
                  r_state    <= ST_SHIFT;
`ifdef USB_TX_CRC16_EN
                  r_pid_byte <= 1'b1;
`endif
               end
            end
            ST_SHIFT: begin
               // Acceptance needs an empty skid, so it never collides with the skid load below.
               if (w_xfer) begin
                  r_skid      <= i_byte_data;
                  r_skid_last <= i_byte_last;
                  r_skid_full <= 1'b1;
                  r_last_acc  <= i_byte_last;
               end
               if (i_bit_ack) begin
                  if (!w_idx_end) begin
                     r_sreg    <= r_sreg >> 1;
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end else if (r_cur_last) begin
`ifdef USB_TX_CRC16_EN
                     r_state   <= ST_CRC;
                     r_crc_idx <= '0;
`else
                     r_state   <= ST_IDLE;
`endif
                  end else if (r_skid_full) begin
                     r_sreg      <= r_skid;
                     r_cur_last  <= r_skid_last;
                     r_skid_full <= 1'b0;
                     r_bit_idx   <= '0;
`ifdef USB_TX_CRC16_EN
                     r_pid_byte  <= 1'b0;
`endif
                  end else begin
                     r_underrun <= 1'b1;
                     r_state    <= ST_UNDERRUN;
                  end
               end
            end
`ifdef USB_TX_CRC16_EN
            ST_CRC: begin
               if (i_bit_ack) begin
                  if (r_crc_idx == 4'd15) r_state <= ST_IDLE;
                  else                    r_crc_idx <= r_crc_idx + 1'b1;
               end
            end
`endif
            ST_UNDERRUN: begin
               if (i_bit_ack) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Underrun forces a last_bit so the encoder closes with a packet the receiver will reject.
   always_comb begin
      o_bit_out  = 1'b0;
      o_last_bit = 1'b0;
      case (r_state)
         ST_SHIFT: begin
            o_bit_out = r_sreg[0];
`ifndef USB_TX_CRC16_EN
            o_last_bit = w_idx_end && r_cur_last;
`endif
         end
`ifdef USB_TX_CRC16_EN
         ST_CRC: begin
            o_bit_out  = ~w_crc[r_crc_idx];
            o_last_bit = (r_crc_idx == 4'd15);
         end
`endif
         ST_UNDERRUN: o_last_bit = 1'b1;
         default: ;
      endcase
   end

   assign o_busy     = (r_state != ST_IDLE);
   assign o_underrun = r_underrun;
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer; covers both builds of USB_TX_CRC16_EN.
module tb_usb_tx_serializer;
   logic       i_clk48 = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_start = 1'b0;
   logic [7:0] i_byte_data = 8'h00;
   logic       i_byte_valid = 1'b0;
   logic       i_byte_last = 1'b0;
   logic       i_bit_ack = 1'b0;
   logic       o_byte_ready, o_bit_out, o_last_bit, o_busy, o_underrun;

   int checks = 0;
   int failures = 0;
   logic [7:0] tx_bytes[$];
   logic       exp_bits[$];

   usb_tx_serializer #(.BYTE_W(8)) dut (
      .i_clk48      (i_clk48),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_byte_data  (i_byte_data),
      .i_byte_valid (i_byte_valid),
      .i_byte_last  (i_byte_last),
      .o_byte_ready (o_byte_ready),
      .o_bit_out    (o_bit_out),
      .o_last_bit   (o_last_bit),
      .i_bit_ack    (i_bit_ack),
      .o_busy       (o_busy),
      .o_underrun   (o_underrun)
   );

   always #5 i_clk48 = ~i_clk48;

   task automatic tick();
      @(posedge i_clk48);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ack_after(input int gap);
      repeat (gap) tick();
      i_bit_ack = 1'b1;
      tick();
      i_bit_ack = 1'b0;
   endtask

   // Reference USB CRC16 over every byte after the PID, LSB first.
   function automatic logic [15:0] crc_ref();
      logic [15:0] c;
      logic [7:0]  b;
      logic        fb;
      c = 16'hFFFF;
      for (int k = 1; k < tx_bytes.size(); k++) begin
         b = tx_bytes[k];
         for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ b[j];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
         end
      end
      return c;
   endfunction

   task automatic build_exp();
      logic [7:0]  b;
      logic [15:0] c;
      exp_bits.delete();
      for (int k = 0; k < tx_bytes.size(); k++) begin
         b = tx_bytes[k];
         for (int j = 0; j < 8; j++) exp_bits.push_back(b[j]);
      end
`ifdef USB_TX_CRC16_EN
      c = crc_ref();
      for (int j = 0; j < 16; j++) exp_bits.push_back(~c[j]);
`else
      c = 16'h0000;
      if (c != 16'h0000) exp_bits.delete();
`endif
   endtask

   // Start a packet, feed tx_bytes with valid held high, ack every 4th cycle, check every bit.
   task automatic run_pkt(input string tag);
      int nbits;
      int nbytes;
      build_exp();
      nbits  = exp_bits.size();
      nbytes = tx_bytes.size();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      fork
         begin
            int wd;
            for (int k = 0; k < nbytes; k++) begin
               i_byte_data  = tx_bytes[k];
               i_byte_last  = (k == nbytes - 1);
               i_byte_valid = 1'b1;
               wd = 0;
               while (!o_byte_ready && wd < 200) begin
                  tick();
                  wd++;
               end
               check($sformatf("%s_feed_timeout%0d", tag, k), (wd < 200), 1);
               tick();
            end
            i_byte_valid = 1'b0;
            i_byte_last  = 1'b0;
         end
         begin
            tick();
            for (int i = 0; i < nbits; i++) begin
               check($sformatf("%s_bit%0d", tag, i), o_bit_out, exp_bits[i]);
               check($sformatf("%s_last%0d", tag, i), o_last_bit, (i == nbits - 1));
               if (i < 8 * nbytes && (i % 8) == 2)
                  check($sformatf("%s_ready_low%0d", tag, i), o_byte_ready, 0);
               ack_after(3);
            end
            check({tag, "_busy_end"}, o_busy, 0);
         end
      join
   endtask

   initial begin
      int n_ack;
      logic [7:0] ubits;

      // Reset state
      repeat (2) tick();
      i_reset = 1'b0;
      check("rst_bit_out", o_bit_out, 0);
      check("rst_last_bit", o_last_bit, 0);
      check("rst_byte_ready", o_byte_ready, 0);
      check("rst_busy", o_busy, 0);
      check("rst_underrun", o_underrun, 0);
      tick();
      check("idle_ack_ignored", o_busy, 0);

      // Single byte 0xA5 (PID-only packet when CRC is enabled)
      tx_bytes = '{8'hA5};
      run_pkt("a5");

      // Two bytes, valid held high, exercising the skid
      tx_bytes = '{8'h0F, 8'hF0};
      run_pkt("skid");

`ifdef USB_TX_CRC16_EN
      tx_bytes = '{8'hC3};
      run_pkt("crc_pid");
      tx_bytes = '{8'hC3, 8'h00, 8'h01, 8'h02, 8'h03};
      run_pkt("crc_pay");
`endif

      // Underrun: first byte supplied, second withheld
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_byte_data  = 8'h55;
      i_byte_last  = 1'b0;
      i_byte_valid = 1'b1;
      tick();
      i_byte_valid = 1'b0;
      ubits = 8'h55;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("ur_bit%0d", i), o_bit_out, ubits[i]);
         ack_after(3);
      end
      check("ur_flag", o_underrun, 1);
      check("ur_bit_out", o_bit_out, 0);
      check("ur_last_bit", o_last_bit, 1);
      check("ur_busy", o_busy, 1);
      ack_after(3);
      check("ur_busy_end", o_busy, 0);
      check("ur_sticky", o_underrun, 1);
      repeat (3) tick();
      check("ur_sticky_idle", o_underrun, 1);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("ur_cleared", o_underrun, 0);
      check("ur_restart_busy", o_busy, 1);
      check("ur_restart_ready", o_byte_ready, 1);

      // Reset asserted mid-SHIFT
      i_byte_data  = 8'hFF;
      i_byte_last  = 1'b1;
      i_byte_valid = 1'b1;
      tick();
      i_byte_valid = 1'b0;
      i_byte_last  = 1'b0;
      repeat (3) ack_after(3);
      check("mid_bit_out", o_bit_out, 1);
      check("mid_busy", o_busy, 1);
      i_reset = 1'b1;
      tick();
      check("mrst_bit_out", o_bit_out, 0);
      check("mrst_last_bit", o_last_bit, 0);
      check("mrst_byte_ready", o_byte_ready, 0);
      check("mrst_busy", o_busy, 0);
      check("mrst_underrun", o_underrun, 0);
      i_reset = 1'b0;
      tick();

      // Start pulsed while busy has no effect
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      i_byte_data  = 8'h3C;
      i_byte_last  = 1'b1;
      i_byte_valid = 1'b1;
      tick();
      i_byte_valid = 1'b0;
      i_byte_last  = 1'b0;
      check("sb_bit0", o_bit_out, 0);
      ack_after(3);
      ack_after(3);
      check("sb_bit2", o_bit_out, 1);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check("sb_bit2_hold", o_bit_out, 1);
      check("sb_busy", o_busy, 1);
      check("sb_ready", o_byte_ready, 0);
      ack_after(2);
      check("sb_bit3", o_bit_out, 1);
      n_ack = 1;
      while (o_busy && n_ack < 64) begin
         ack_after(1);
         n_ack++;
      end
`ifdef USB_TX_CRC16_EN
      check("sb_acks_to_idle", n_ack, 22);
`else
      check("sb_acks_to_idle", n_ack, 6);
`endif
      check("sb_underrun", o_underrun, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
- Upstream feeder for the USB full-speed JK/NRZI encoder.
- Accepts packet bytes (PID first) on a valid/ready byte stream and presents them LSB-first on bit_out, one bit at a time.
- Advances to the next bit on the encoder's bit_ack pulse and flags the final bit on last_bit.
- Optionally serialises and appends the USB CRC16 over all bytes after the PID.

Parameters:
- BYTE_W, 8, byte width; fixed at 8 for USB, parameterised only so the index counters are derived from it.

Ports:
- clk48  in  1  48 MHz clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a packet; ignored while busy=1
- byte_data  in  8  packet byte
- byte_valid  in  1  byte_data valid
- byte_last  in  1  qualifies the final byte of the packet
- byte_ready  out  1  block can accept a byte this cycle
- bit_out  out  1  current bit to the encoder (connects to encoder bit_in)
- last_bit  out  1  the currently presented bit is the packet's final bit
- bit_ack  in  1  encoder consumed the current bit
- busy  out  1  packet in progress
- underrun  out  1  sticky; byte stream starved mid-packet

Behaviour:
- Clock and reset: one clock (clk48); reset is synchronous and active-high.
- Reset values: bit_out=0, last_bit=0, byte_ready=0, busy=0, underrun=0; state=IDLE; skid buffer empty; all counters 0. Reset mid-packet aborts immediately, with no completion behaviour.
- Storage: shift register sreg[7:0] plus cur_last flag; one-byte skid register plus skid_last and skid_full; bit index bit_idx[2:0].
- Byte handshake: a byte transfers when byte_valid && byte_ready. byte_ready=1 only when all of these hold:
  - state is FILL or SHIFT;
  - skid is empty;
  - the last byte has not yet been accepted.
- bit_out = sreg[0] in SHIFT, 0 otherwise. All outputs are combinational from registers; none depend on bit_ack in the same cycle.
- State machine:
  - IDLE:
    - start -> FILL, and underrun is cleared.
    - bit_ack is ignored.
  - FILL:
    - The first accepted byte loads sreg directly; bit_idx=0; then -> SHIFT.
    - The first valid bit is therefore visible 1 cycle after the transfer. Upstream must supply the PID before the encoder leaves SYNC; this is the integration rule.
  - SHIFT, on bit_ack:
    - bit_idx<7: shift sreg right, bit_idx+1.
    - bit_idx==7 and !cur_last and skid_full: load skid into sreg; skid empty; bit_idx=0.
    - bit_idx==7 and cur_last: -> CRC if the feature is enabled, else -> IDLE.
    - bit_idx==7 and !cur_last and !skid_full: underrun=1; -> UNDERRUN.
  - A byte accepted in the same cycle as a skid-to-sreg load goes into the skid register. Accept and load never conflict, because acceptance requires an empty skid.
  - UNDERRUN:
    - bit_out=0, last_bit=1, so the encoder terminates with a truncated packet that the receiver rejects.
    - On bit_ack -> IDLE.
    - underrun stays set until the next accepted start.
  - last_bit (feature disabled) = SHIFT && bit_idx==7 && cur_last.
- busy=1 in every state except IDLE; it drops the cycle after the final bit_ack.
- bit_ack in FILL is ignored (encoder still in SYNC).

Optional Feature:
- Macro: USB_TX_CRC16_EN.
- When defined:
  - Serial CRC16: polynomial 0x8005 (reflected 0xA001), init 0xFFFF.
  - Updated with bit_out on each bit_ack in SHIFT, except during the first byte (PID).
  - After the last byte's bit 7 ack -> state CRC: present ~crc LSB-first for 16 bits, crc_idx[3:0] advancing on bit_ack.
  - last_bit = CRC && crc_idx==15; SHIFT never asserts last_bit.
  - The CRC register reinitialises on start.
- When undefined: no CRC state or logic; the packet ends with the last byte's bit 7.

Decomposition:
- Package usb_tx_pkg:
  - serializer state enum (IDLE, FILL, SHIFT, CRC, UNDERRUN);
  - CRC16_POLY_REFL = 16'hA001, CRC16_INIT = 16'hFFFF;
  - BYTE_W.
- Sub-module usb_crc16_serial: 1-bit-per-enable CRC16 engine with init/enable/bit inputs. It is shared with the future receive path.

Test Plan:
- Single byte 0xA5 with byte_last=1; ack each bit 4 cycles apart:
  - bit_out = 1,0,1,0,0,1,0,1;
  - last_bit=1 only during the 8th bit;
  - busy=0 one cycle after the 8th ack.
- Bytes 0x0F, 0xF0 (last) with bit_ack every 4 cycles and byte_valid always high:
  - 16 gap-free bits 1111000000001111;
  - byte_ready low while the skid is full.
- Two-byte packet with the second byte withheld:
  - after the 8th ack: underrun=1, bit_out=0, last_bit=1;
  - next ack -> busy=0;
  - underrun stays 1 until the next start, which clears it.
- With USB_TX_CRC16_EN, PID-only packet 0xC3 (last):
  - 8 PID bits, then 16 zeros (complement of untouched 0xFFFF);
  - last_bit only on the 16th CRC bit.
- With USB_TX_CRC16_EN, payload 0x00,0x01,0x02,0x03 after a PID: the 16 CRC bits match a bench reference CRC16 model bit-for-bit.
- Reset asserted mid-SHIFT and start pulsed while busy:
  - all outputs at reset values the next cycle;
  - a start while busy causes no state change.
